uart_rx_os16: RTL and testbench
===============================

// Module: uart_rx_os16
// PURPOSE
//  Standalone 8N1 UART receiver with 16x oversampling, mid-bit sampling, start-glitch
//  rejection, and framing/overrun flags. Complements the existing transmitter for
//  loopback and external-line reception.
//  Presents received bytes on data_out with a ready/ready_clr handshake (uart convention).
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency (Hz)
//  BAUD        115200      line rate (bit/s)
//  OS_DIV      CLK_HZ/(BAUD*16)  clocks per oversample tick; derived, integer-truncated, must be >=1
// PORTS
//  clk_50m    in   1  system clock; all logic on posedge
//  rst        in   1  synchronous reset, active-high
//  Rx         in   1  serial line, idle high, asynchronous to clk_50m
//  Rx_en      in   1  level enable; new start bits accepted only while high
//  ready_clr  in   1  one-cycle pulse: clears ready, frame_err, overrun
//  data_out   out  8  last good byte, LSB received first
//  ready      out  1  byte available in data_out
//  frame_err  out  1  stop bit sampled low on the last frame
//  overrun    out  1  byte completed while ready was still high
//  Rx_busy    out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: data_out=0, ready=0, frame_err=0, overrun=0, Rx_busy=0; state=IDLE.
//   Synchroniser FFs=1; tick counter=0; sample counter=0; bit index=0; armed=0.
//  Synchroniser: 2 flops on Rx -> rx_s. All decisions use rx_s (2-cycle input latency).
//  Tick: counter 0..OS_DIV-1, free-running; tick=1 for one cycle when it equals OS_DIV-1.
//  armed: set when rx_s=1 is seen in IDLE. Cleared on leaving IDLE. Blocks re-trigger on a
//   held-low line (break or stop-bit error).
//  FSM (sample counter s[3:0] advances only on tick):
//   IDLE:  Rx_en=1 & armed & rx_s=0 -> START, s=0.
//   START: on the tick with s==7 (mid start bit): rx_s=0 -> DATA, s=0, bit index=0;
//          rx_s=1 -> IDLE (glitch). No flags change on a glitch.
//   DATA:  on the tick with s==15 (mid bit): shift rx_s into sreg[7] (shift right, LSB first),
//          then increment bit index. After the 8th bit -> STOP, s=0.
//   STOP:  on the tick with s==15 (mid stop bit):
//          rx_s=1: data_out<=sreg; ready<=1; frame_err<=0; overrun<=ready (old value).
//          rx_s=0: frame_err<=1; data_out, ready and overrun unchanged.
//          Both cases -> IDLE.
//  Latency: flags and data_out update on the clock edge after the mid-stop tick.
//   Measured from the Rx falling edge, this is about 9.5 bit times + 3 clocks.
//  ready_clr=1 clears ready, frame_err and overrun on the next edge.
//   If ready_clr coincides with a set event in the same cycle, the set wins.
//  Rx_en=0 mid-frame does not abort the frame. It only blocks the next start bit.
//  rst mid-frame: abandon the frame immediately, with all values as listed for reset. No partial byte is output.
//  Back-to-back frames: a start edge may be accepted from the cycle after STOP exits.
//   No minimum idle time is required beyond the stop bit's second half.
// TESTING (bench: CLK_HZ=1_600, BAUD=100 -> OS_DIV=1, 16 clk/bit)
//  1. Send 0xA5 8N1 with Rx_en=1 -> data_out=0xA5, ready=1, frame_err=0, overrun=0
//     ~155 clks after the start edge.
//  2. 0x00..0xFF back-to-back, ready_clr pulsed after each ready -> every byte matches;
//     overrun never set.
//  3. Rx low for 5 clks, then high -> stays IDLE; ready=0; Rx_busy pulses once, no flags.
//  4. Send 0x3C with stop bit forced 0 -> frame_err=1, ready=0, data_out keeps its prior value.
//     No new frame is accepted until Rx returns high.
//  5. Send 0x11 then 0x22 without ready_clr -> data_out=0x22, ready=1, overrun=1.
//     A single ready_clr then clears all three flags.
//  6. Assert rst during bit 4 of 0x5A -> all outputs are 0 next cycle.
//     The following clean 0x5A is received correctly.
//     Also: Rx_en=0 with a frame sent -> no ready.

Source files
------------

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling with start-glitch rejection.
// Presents bytes on data_out with a ready / ready_clr handshake plus framing and overrun flags.
module uart_rx_os16 #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       Rx,
  input  logic       Rx_en,
  input  logic       ready_clr,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       Rx_busy
);

  // A truncated divider of zero would stall the receiver, so clamp it to one.
  localparam int OS_DIV = (CLK_HZ / (BAUD * 16) < 1) ? 1 : CLK_HZ / (BAUD * 16);
  localparam int TW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [TW-1:0] TLAST = TW'(OS_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rx_s_q;
  logic [TW-1:0] tcnt_q;
  logic          tick;
  logic [3:0]    s_q, s_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sreg_q, sreg_d;
  logic          armed_q, armed_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  assign tick = (tcnt_q == TLAST);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      tcnt_q  <= '0;
      state_q <= IDLE;
      s_q     <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= Rx;
      rx_s_q  <= sync1_q;
      tcnt_q  <= tick ? '0 : tcnt_q + 1'b1;
      state_q <= state_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    armed_d = armed_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // Clear first so a completing frame in the same cycle overrides it.
    if (ready_clr) begin
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    if (tick) s_d = s_q + 4'd1;

    case (state_q)
      IDLE: begin
        // Arming needs a high line first, so a held-low break never retriggers.
        if (rx_s_q) armed_d = 1'b1;
        if (Rx_en && armed_q && !rx_s_q) begin
          state_d = START;
          s_d     = '0;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (tick && s_q == 4'd7) begin
          s_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (tick && s_q == 4'd15) begin
          sreg_d = {rx_s_q, sreg_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            s_d     = '0;
          end
        end
      end
      STOP: begin
        if (tick && s_q == 4'd15) begin
          state_d = IDLE;
          if (rx_s_q) begin
            data_d  = sreg_q;
            ready_d = 1'b1;
            ferr_d  = 1'b0;
            ovr_d   = ready_q;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign ready     = ready_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign Rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: frame-level model (completion times from bit arithmetic) checked
// every cycle, plus literal expectations for each directed scenario.
module tb_uart_rx_os16;
  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  // Rx driven just after edge P: 2 sync flops + 1 detect edge + 8 + 8*16 + 16 ticks.
  localparam int T_BUSY = 3;
  localparam int T_DONE = 3 + 8 + 8 * 16 + 16;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       Rx = 1'b1;
  logic       Rx_en = 1'b1;
  logic       ready_clr = 1'b0;
  logic [7:0] data_out;
  logic       ready, frame_err, overrun, Rx_busy;

  uart_rx_os16 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_50m(clk_50m), .rst(rst), .Rx(Rx), .Rx_en(Rx_en), .ready_clr(ready_clr),
    .data_out(data_out), .ready(ready), .frame_err(frame_err), .overrun(overrun),
    .Rx_busy(Rx_busy)
  );

  always #5 clk_50m = ~clk_50m;

  // kind: 0 = glitch (busy only), 1 = good byte, 2 = framing error
  typedef struct {
    int         bs;
    int         be;
    int         kind;
    logic [7:0] b;
  } frm_t;

  frm_t       q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         last_rise = -1;
  int         n_rise = 0;
  logic       prev_rdy = 1'b0;
  logic [7:0] m_data;
  logic       m_ready, m_ferr, m_ovr, m_busy, m_old;
  bit         chk_en = 0;
  bit         auto_clr = 0;
  bit         man_clr = 0;

  // Frame-level model of the output registers.
  initial forever begin
    @(posedge clk_50m);
    cyc++;
    if (rst) begin
      m_data = 8'h00; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      q.delete();
    end else begin
      m_old = m_ready;
      if (ready_clr) begin
        m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      end
      if (q.size() > 0 && q[0].be == cyc) begin
        if (q[0].kind == 1) begin
          m_data = q[0].b; m_ready = 1'b1; m_ferr = 1'b0; m_ovr = m_old;
        end else if (q[0].kind == 2) begin
          m_ferr = 1'b1;
        end
        q.delete(0);
      end
    end
    m_busy = (q.size() > 0) && (q[0].bs <= cyc);
  end

  initial forever begin
    @(negedge clk_50m);
    if (chk_en) begin
      n_cmp++;
      if ({data_out, ready, frame_err, overrun, Rx_busy} !==
          {m_data, m_ready, m_ferr, m_ovr, m_busy}) begin
        n_err++;
        $display("FAIL model cyc=%0d got data=%h rdy=%b fe=%b ov=%b busy=%b want data=%h rdy=%b fe=%b ov=%b busy=%b",
                 cyc, data_out, ready, frame_err, overrun, Rx_busy,
                 m_data, m_ready, m_ferr, m_ovr, m_busy);
      end
    end
  end

  // Sole driver of ready_clr: manual pulses or automatic ack of each ready.
  initial forever begin
    @(posedge clk_50m);
    #2;
    ready_clr = man_clr | (auto_clr & (ready === 1'b1));
  end

  initial forever begin
    @(posedge clk_50m);
    #1;
    if (ready === 1'b1 && prev_rdy !== 1'b1) begin
      last_rise = cyc;
      n_rise++;
    end
    prev_rdy = ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  task automatic clr_pulse();
    man_clr = 1'b1;
    step(1);
    man_clr = 1'b0;
    step(1);
  endtask

  // Caller sits #1 after an edge; kind < 0 means the frame must not be accepted.
  task automatic send(input logic [7:0] b, input logic stopv, input int kind);
    int p;
    p = cyc;
    if (kind >= 0) q.push_back('{p + T_BUSY, p + T_DONE, kind, b});
    Rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      step(16);
    end
    Rx = stopv;
    step(16);
  endtask

  initial begin
    int p;
    logic [7:0] b;
    step(3);
    chk("reset data_out", data_out, 8'h00);
    chk("reset ready", ready, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    chk("reset busy", Rx_busy, 1'b0);
    rst = 1'b0;
    chk_en = 1;
    step(4);

    // Single clean byte and its latency from the start edge.
    p = cyc;
    send(8'hA5, 1'b1, 1);
    chk("t1 data", data_out, 8'hA5);
    chk("t1 ready", ready, 1'b1);
    chk("t1 fe", frame_err, 1'b0);
    chk("t1 ov", overrun, 1'b0);
    chk("t1 latency", last_rise - p, 155);
    clr_pulse();
    chk("t1 clr ready", ready, 1'b0);

    // Short low glitch: busy for the half start bit, then back to idle.
    p = cyc;
    q.push_back('{p + T_BUSY, p + 11, 0, 8'h00});
    Rx = 1'b0;
    step(5);
    Rx = 1'b1;
    chk("glitch busy", Rx_busy, 1'b1);
    step(10);
    chk("glitch idle", Rx_busy, 1'b0);
    chk("glitch ready", ready, 1'b0);
    chk("glitch fe", frame_err, 1'b0);

    // Stop bit low, line then held low: no retrigger until it goes high.
    send(8'h3C, 1'b0, 2);
    step(40);
    chk("ferr fe", frame_err, 1'b1);
    chk("ferr ready", ready, 1'b0);
    chk("ferr data kept", data_out, 8'hA5);
    chk("ferr held low idle", Rx_busy, 1'b0);
    Rx = 1'b1;
    step(8);
    clr_pulse();
    chk("ferr cleared", frame_err, 1'b0);

    // Every byte value back-to-back, each acknowledged.
    auto_clr = 1;
    n_rise = 0;
    for (int i = 0; i < 256; i++) send(8'(i), 1'b1, 1);
    step(4);
    auto_clr = 0;
    chk("sweep count", n_rise, 256);
    chk("sweep last data", data_out, 8'hFF);
    chk("sweep ov", overrun, 1'b0);

    // Two bytes without acknowledge -> overrun.
    send(8'h11, 1'b1, 1);
    send(8'h22, 1'b1, 1);
    step(2);
    chk("ovr data", data_out, 8'h22);
    chk("ovr ready", ready, 1'b1);
    chk("ovr flag", overrun, 1'b1);
    clr_pulse();
    chk("ovr clr ready", ready, 1'b0);
    chk("ovr clr flag", overrun, 1'b0);
    chk("ovr clr fe", frame_err, 1'b0);
    chk("ovr clr data kept", data_out, 8'h22);

    // Receiver disabled: frame ignored.
    Rx_en = 1'b0;
    send(8'hC3, 1'b1, -1);
    step(4);
    chk("disabled ready", ready, 1'b0);
    chk("disabled data", data_out, 8'h22);
    Rx_en = 1'b1;
    step(4);

    // Reset during bit 4, then a clean repeat of the byte.
    b = 8'h5A;
    p = cyc;
    q.push_back('{p + T_BUSY, p + T_DONE, 1, b});
    Rx = 1'b0;
    step(16);
    for (int i = 0; i < 4; i++) begin
      Rx = b[i];
      step(16);
    end
    Rx = b[4];
    step(8);
    chk("rst mid busy", Rx_busy, 1'b1);
    rst = 1'b1;
    Rx = 1'b1;
    step(1);
    chk("rst data", data_out, 8'h00);
    chk("rst ready", ready, 1'b0);
    chk("rst busy", Rx_busy, 1'b0);
    rst = 1'b0;
    step(6);
    send(8'h5A, 1'b1, 1);
    step(2);
    chk("after rst data", data_out, 8'h5A);
    chk("after rst ready", ready, 1'b1);
    chk("after rst ov", overrun, 1'b0);
    step(4);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
